pixdcm_supervisor: RTL

- Drives the `reset_pixdcm` input of the clock block, which is the reset of the pixel-capture DCM.
- Supervises that DCM's recovery of the sensor PIX_CLK: holds it in reset, waits for lock and a live pixel clock, and re-resets it on loss.
- Runs in the `clk0` logic domain and gives the capture datapath and host registers a clean `pix_ready` qualifier plus fault and statistics status.
- Gives up after repeated failed lock attempts. Host restart is available at any time.

---
 rtl/pixdcm_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 38 +++
 rtl/pixdcm_supervisor.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pixdcm_pkg.sv
// -----------------------------------------------------------------------------
// pixdcm_pkg
//   Shared types and constants for the pixel-capture DCM supervisor.
//   - state_t      : supervisor FSM states (2-bit encoding)
//   - RETRY_W      : width of the failed-attempt counter
//   - DEF_*        : default timing parameters for a 124 MHz clk0 domain
//   - timer_width(): width of the single shared timer, sized so it can hold
//                    the largest terminal count of the three timed phases
// -----------------------------------------------------------------------------
package pixdcm_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,   // DCM held in reset
        WAIT  = 2'd1,   // reset released, waiting for lock + live pixel clock
        RUN   = 2'd2,   // pixel clock qualified, capture may proceed
        FAULT = 2'd3    // retry budget exhausted, host restart required
    } state_t;

    localparam int RETRY_W = 3;

    localparam int DEF_RST_HOLD_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT    = 262144;
    localparam int DEF_HB_TIMEOUT      = 64;
    localparam int DEF_HB_CONFIRM      = 8;
    localparam int DEF_MAX_RETRIES     = 7;
    localparam int DEF_CNT_W           = 8;

    // The timer only ever counts up to (limit - 1), so clog2 of the largest
    // limit is enough bits. Never narrower than one bit.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for asynchronous level signals entering clk.
//   Both stages carry ASYNC_REG so placement keeps them adjacent.
//
// Ports:
//   clk  in  1  destination clock
//   rst  in  1  asynchronous active-high reset (stages clear to 0)
//   d    in  W  asynchronous inputs
//   q    out W  synchronized outputs (second stage)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [W-1:0] stage1;
    (* ASYNC_REG = "TRUE" *) logic [W-1:0] stage2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1 <= '0;
            stage2 <= '0;
        end else begin
            // NOTE: non-blocking so stage2 takes the old stage1; blocking would
            // collapse the two stages into a single metastable flop.
            stage1 <= d;
            stage2 <= stage1;
        end
    end

    assign q = stage2;

endmodule

// File: rtl/pixdcm_supervisor.sv
// -----------------------------------------------------------------------------
// pixdcm_supervisor
//   Drives the reset of the pixel-capture DCM that recovers the sensor PIX_CLK.
//   Holds the DCM in reset, waits for LOCKED plus a live pixel-clock heartbeat,
//   qualifies the clock with pix_ready, and re-resets the DCM on loss of lock,
//   input-clock stop or heartbeat timeout. After too many consecutive failed
//   lock attempts it parks in FAULT until the host pulses restart.
//
// Ports:
//   clk0          in  1      logic clock
//   rst0          in  1      asynchronous active-high reset
//   restart       in  1      clk0-synchronous pulse, fresh attempt from any state
//   dcm_locked    in  1      DCM LOCKED (asynchronous)
//   clkin_stopped in  1      DCM STATUS[1] (asynchronous)
//   pix_hb        in  1      divide-by-2 toggle from clk_pix (asynchronous)
//   reset_pixdcm  out 1      DCM reset
//   pix_ready     out 1      pixel clock valid and locked
//   fault         out 1      retry budget exhausted
//   retry_count   out 3      failed attempts since last RUN or restart
//   loss_count    out CNT_W  saturating count of RUN->HOLD events
// -----------------------------------------------------------------------------
module pixdcm_supervisor
    import pixdcm_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int HB_TIMEOUT      = DEF_HB_TIMEOUT,
    parameter int HB_CONFIRM      = DEF_HB_CONFIRM,
    parameter int MAX_RETRIES     = DEF_MAX_RETRIES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic               clk0,
    input  logic               rst0,
    input  logic               restart,
    input  logic               dcm_locked,
    input  logic               clkin_stopped,
    input  logic               pix_hb,
    output logic               reset_pixdcm,
    output logic               pix_ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic [CNT_W-1:0]   loss_count
);

    localparam int TIMER_W = timer_width(LOCK_TIMEOUT, HB_TIMEOUT, RST_HOLD_CYCLES);
    localparam int HBC_W   = $clog2(HB_CONFIRM + 1);

    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST  = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] HB_LAST    = TIMER_W'(HB_TIMEOUT - 1);
    localparam logic [HBC_W-1:0]   HBC_FULL   = HBC_W'(HB_CONFIRM);
    localparam logic [HBC_W-1:0]   HBC_ONE    = HBC_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);
    localparam logic [CNT_W-1:0]   LOSS_ONE   = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Input synchronization
    // -------------------------------------------------------------------------
    logic [2:0] async_in;
    logic [2:0] sync_out;
    logic       locked_s;
    logic       stopped_s;
    logic       hb_s2;
    logic       hb_s3;
    logic       hb_edge;

    assign async_in = {pix_hb, clkin_stopped, dcm_locked};

    sync_2ff #(
        .W (3)
    ) u_sync (
        .clk (clk0),
        .rst (rst0),
        .d   (async_in),
        .q   (sync_out)
    );

    assign locked_s  = sync_out[0];
    assign stopped_s = sync_out[1];
    assign hb_s2     = sync_out[2];

    // pix_hb toggles once per pixel clock pair; any change between the second
    // and third stage is one heartbeat, independent of direction.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            hb_s3 <= 1'b0;
        end else begin
            hb_s3 <= hb_s2;
        end
    end

    assign hb_edge = hb_s2 ^ hb_s3;

    // -------------------------------------------------------------------------
    // FSM and counters
    //   One timer serves all three timed phases: the HOLD length, the WAIT lock
    //   timeout and the RUN heartbeat watchdog. It is cleared on every state
    //   change, so each phase starts counting from zero.
    // -------------------------------------------------------------------------
    state_t               state_q,    state_d;
    logic [TIMER_W-1:0]   timer_q,    timer_d;
    logic [HBC_W-1:0]     hb_edges_q, hb_edges_d;
    logic [RETRY_W-1:0]   retry_q,    retry_d;
    logic [CNT_W-1:0]     loss_q,     loss_d;
    logic                 run_loss;

    // Loss is evaluated before the heartbeat so a heartbeat on the same cycle
    // cannot rescue a lost lock or a stopped input clock.
    assign run_loss = !locked_s || stopped_s || (timer_q == HB_LAST);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        hb_edges_d = hb_edges_q;
        retry_d    = retry_q;
        loss_d     = loss_q;

        if (restart) begin
            // Host restart overrides everything; loss history is kept.
            state_d    = HOLD;
            timer_d    = '0;
            hb_edges_d = '0;
            retry_d    = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (timer_q == HOLD_LAST) begin
                        state_d    = WAIT;
                        timer_d    = '0;
                        hb_edges_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end

                WAIT: begin
                    // Success is tested first so a lock arriving on the final
                    // timeout cycle still counts as a good attempt.
                    if (locked_s && !stopped_s && (hb_edges_q == HBC_FULL)) begin
                        state_d = RUN;
                        timer_d = '0;
                        retry_d = '0;
                    end else if (timer_q == LOCK_LAST) begin
                        timer_d = '0;
                        if (retry_q == RETRY_LAST) begin
                            state_d = FAULT;
                        end else begin
                            state_d = HOLD;
                            retry_d = retry_q + RETRY_ONE;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                        if (hb_edge && (hb_edges_q < HBC_FULL)) begin
                            hb_edges_d = hb_edges_q + HBC_ONE;
                        end
                    end
                end

                RUN: begin
                    if (run_loss) begin
                        state_d = HOLD;
                        timer_d = '0;
                        if (loss_q != '1) begin
                            loss_d = loss_q + LOSS_ONE;
                        end
                    end else if (hb_edge) begin
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end

                FAULT: begin
                    timer_d = '0;
                end

                default: begin
                    state_d = HOLD;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state and never come from a combinational decode.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q      <= HOLD;
            timer_q      <= '0;
            hb_edges_q   <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            reset_pixdcm <= 1'b1;
            pix_ready    <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            hb_edges_q   <= hb_edges_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            reset_pixdcm <= (state_d == HOLD) || (state_d == FAULT);
            pix_ready    <= (state_d == RUN);
            fault        <= (state_d == FAULT);
        end
    end

    assign retry_count = retry_q;
    assign loss_count  = loss_q;

endmodule
